fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_fb_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: display line prefetch into a line buffer with
// camera writes forced in after every BURST reads, plus overrun detection.
module fb_arbiter #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16,
    parameter int BURST  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_req,
    input  logic [7:0]        line_num,
    input  logic              cam_wr_req,
    input  logic [ADDR_W-1:0] cam_wr_addr,
    input  logic [DATA_W-1:0] cam_wr_data,
    output logic              cam_wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [8:0]        lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              line_done,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic [1:0] {IDLE, CAM_WR, DISP_RD, DRAIN} state_t;

    state_t            r_state;
    logic [7:0]        r_line;
    logic [8:0]        r_col;
    logic [BW-1:0]     r_burst;
    logic              r_in_line;
    logic              r_reads_done;
    logic              r_drain;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_overrun;
    logic              r_s1_v;
    logic [8:0]        r_s1_col;
    logic              r_lb_we;
    logic [8:0]        r_lb_waddr;
    logic              r_line_done;

    logic [8:0]        w_col_next;
    logic [BW-1:0]     w_burst_next;
    logic              w_burst_full;
    logic              w_last_col;
    logic              w_line_ok;
    logic [ADDR_W-1:0] w_addr_start;
    logic [ADDR_W-1:0] w_addr_cur;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_col_next   = r_col + 9'd1;
    assign w_burst_next = r_burst + 1'b1;
    assign w_burst_full = (w_burst_next == BW'(BURST));
    assign w_last_col   = (r_col == 9'(IMG_W - 1));
    assign w_line_ok    = (32'(line_num) < 32'(IMG_H));
    assign w_addr_start = ADDR_W'(32'(line_num) * 32'(IMG_W));
    assign w_addr_cur   = ADDR_W'(32'(r_line) * 32'(IMG_W) + 32'(r_col));
    assign w_addr_next  = ADDR_W'(32'(r_line) * 32'(IMG_W) + 32'(w_col_next));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_line       <= '0;
            r_col        <= '0;
            r_burst      <= '0;
            r_in_line    <= 1'b0;
            r_reads_done <= 1'b0;
            r_drain      <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            // NOTE: strobes default low on every edge; a state re-asserts them
            // only for the cycle it owns, so they can never stick high.
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (line_req) begin
                        if (w_line_ok) begin
                            r_state      <= DISP_RD;
                            r_busy       <= 1'b1;
                            r_line       <= line_num;
                            r_col        <= '0;
                            r_burst      <= '0;
                            r_in_line    <= 1'b1;
                            r_reads_done <= 1'b0;
                            r_mem_re     <= 1'b1;
                            r_mem_addr   <= w_addr_start;
                        end
                    end else if (cam_wr_req) begin
                        r_state     <= CAM_WR;
                        r_busy      <= 1'b1;
                        r_in_line   <= 1'b0;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= cam_wr_addr;
                        r_mem_wdata <= cam_wr_data;
                    end
                end
                DISP_RD: begin
                    if (w_burst_full && cam_wr_req) begin
                        r_state      <= CAM_WR;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= cam_wr_addr;
                        r_mem_wdata  <= cam_wr_data;
                        r_burst      <= '0;
                        r_col        <= w_col_next;
                        r_reads_done <= w_last_col;
                    end else if (w_last_col) begin
                        r_state <= DRAIN;
                        r_drain <= 1'b0;
                    end else begin
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= w_addr_next;
                        r_col      <= w_col_next;
                        // Saturate so a late camera request goes in at the next read slot.
                        if (!w_burst_full) r_burst <= w_burst_next;
                    end
                end
                CAM_WR: begin
                    if (!r_in_line) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_reads_done) begin
                        r_state <= DRAIN;
                        r_drain <= 1'b0;
                    end else begin
                        r_state    <= DISP_RD;
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= w_addr_cur;
                    end
                end
                DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_in_line <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           r_overrun <= 1'b0;
        else if (line_req && r_state != IDLE) r_overrun <= 1'b1;
        else if (overrun_clr)                 r_overrun <= 1'b0;
    end

    // Two-stage column pipeline aligned with the memory's fixed read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_v      <= 1'b0;
            r_s1_col    <= '0;
            r_lb_we     <= 1'b0;
            r_lb_waddr  <= '0;
            r_line_done <= 1'b0;
        end else begin
            r_s1_v      <= r_mem_re;
            r_s1_col    <= r_col;
            r_lb_we     <= r_s1_v;
            r_lb_waddr  <= r_s1_col;
            r_line_done <= r_s1_v && (r_s1_col == 9'(IMG_W - 1));
        end
    end

    assign mem_re     = r_mem_re;
    assign mem_we     = r_mem_we;
    assign cam_wr_ack = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign lb_we      = r_lb_we;
    assign lb_waddr   = r_lb_waddr;
    assign line_done  = r_line_done;
    assign lb_wdata   = r_lb_we ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: constant vectors, directed line-fetch
// scenarios and a randomized phase, all scored against a per-cycle model.
module tb_fb_arbiter;
    localparam int IMG_W  = 320;
    localparam int IMG_H  = 240;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    localparam int BURST  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              line_req = 1'b0;
    logic [7:0]        line_num = '0;
    logic              cam_wr_req = 1'b0;
    logic [ADDR_W-1:0] cam_wr_addr = '0;
    logic [DATA_W-1:0] cam_wr_data = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              overrun_clr = 1'b0;
    logic              cam_wr_ack, mem_we, mem_re, lb_we, line_done, busy, overrun;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, lb_wdata;
    logic [8:0]        lb_waddr;

    always #5 clk = ~clk;

    fb_arbiter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
        .clk(clk), .reset(reset), .line_req(line_req), .line_num(line_num),
        .cam_wr_req(cam_wr_req), .cam_wr_addr(cam_wr_addr), .cam_wr_data(cam_wr_data),
        .cam_wr_ack(cam_wr_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
        .line_done(line_done), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_READ, M_WRITE, M_DRAIN} m_act_e;
    typedef struct { int cyc; int col; logic [ADDR_W-1:0] addr; } lb_t;

    m_act_e            m_act = M_IDLE;
    int                m_line = 0, m_col = 0, m_since = 0, m_drain = 0;
    bit                m_fetch = 0, m_done = 0, m_ovr = 0;
    logic [ADDR_W-1:0] m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    lb_t               lb_q[$];

    function automatic logic [ADDR_W-1:0] rd_addr(input int line, input int col);
        return ADDR_W'(line * IMG_W + col);
    endfunction

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return DATA_W'(a * 5) ^ 16'h3C5A;
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_act = M_IDLE; m_ovr = 0; m_fetch = 0; lb_q.delete();
            return;
        end
        if (line_req && m_act != M_IDLE) m_ovr = 1;
        else if (overrun_clr)            m_ovr = 0;
        case (m_act)
            M_IDLE: begin
                if (line_req && line_num < IMG_H) begin
                    m_fetch = 1; m_line = line_num; m_col = 0; m_since = 0; m_done = 0;
                    m_act = M_READ;
                end else if (!line_req && cam_wr_req) begin
                    m_fetch = 0; m_act = M_WRITE; m_waddr = cam_wr_addr; m_wdata = cam_wr_data;
                end
            end
            M_READ: begin
                m_since++;
                if (m_since >= BURST && cam_wr_req) begin
                    m_act = M_WRITE; m_since = 0; m_done = (m_col == IMG_W - 1); m_col++;
                    m_waddr = cam_wr_addr; m_wdata = cam_wr_data;
                end else if (m_col == IMG_W - 1) begin
                    m_act = M_DRAIN; m_drain = 2;
                end else begin
                    m_col++;
                end
            end
            M_WRITE: begin
                if (!m_fetch)    m_act = M_IDLE;
                else if (m_done) begin m_act = M_DRAIN; m_drain = 2; end
                else             m_act = M_READ;
            end
            M_DRAIN: begin
                m_drain--;
                if (m_drain == 0) begin m_act = M_IDLE; m_fetch = 0; end
            end
            default: m_act = M_IDLE;
        endcase
        if (m_act == M_READ) lb_q.push_back('{cyc + 2, m_col, rd_addr(m_line, m_col)});
    endtask

    task automatic compare_all();
        bit exp_lb;
        exp_lb = (lb_q.size() > 0) && (lb_q[0].cyc == cyc);
        check("mem_re", mem_re, m_act == M_READ);
        check("mem_we", mem_we, m_act == M_WRITE);
        check("cam_wr_ack", cam_wr_ack, m_act == M_WRITE);
        check("busy", busy, m_act != M_IDLE);
        check("overrun", overrun, m_ovr);
        if (m_act == M_READ) check("rd_addr", mem_addr, rd_addr(m_line, m_col));
        if (m_act == M_WRITE) begin
            check("wr_addr", mem_addr, m_waddr);
            check("wr_data", mem_wdata, m_wdata);
        end
        check("lb_we", lb_we, exp_lb);
        if (exp_lb) begin
            check("lb_waddr", lb_waddr, lb_q[0].col);
            check("lb_wdata", lb_wdata, pat(lb_q[0].addr));
            check("line_done", line_done, lb_q[0].col == IMG_W - 1);
            void'(lb_q.pop_front());
        end else begin
            check("line_done", line_done, 0);
        end
    endtask

    // ---------------- memory, camera agent, statistics ----------------
    logic              re_d1 = 0, re_d2 = 0;
    logic [ADDR_W-1:0] addr_d1 = '0, addr_d2 = '0;
    int cam_mode = 0;  // 0 manual, 1 continuous, 2 random
    int n_re, n_ack, n_lb, n_done, n_busy, first_re_addr, last_re_addr, first_ack_cyc, done_cyc, idle_cyc;

    task automatic clear_stats();
        n_re = 0; n_ack = 0; n_lb = 0; n_done = 0; n_busy = 0;
        first_re_addr = -1; last_re_addr = -1; first_ack_cyc = -1; done_cyc = -1;
    endtask

    task automatic new_cam();
        cam_wr_addr = ADDR_W'($urandom);
        cam_wr_data = DATA_W'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        mem_rdata = re_d2 ? pat(addr_d2) : DATA_W'($urandom);
        re_d2 = re_d1; addr_d2 = addr_d1;
        re_d1 = mem_re; addr_d1 = mem_addr;
        #1;
        compare_all();
        if (mem_re) begin
            if (n_re == 0) first_re_addr = int'(mem_addr);
            last_re_addr = int'(mem_addr);
            n_re++;
        end
        if (cam_wr_ack) begin
            if (n_ack == 0) first_ack_cyc = cyc;
            n_ack++;
        end
        if (lb_we) n_lb++;
        if (line_done) begin n_done++; done_cyc = cyc; end
        if (busy) n_busy++;
        if (cam_mode == 1) begin
            if (cam_wr_ack) new_cam();
            cam_wr_req = 1'b1;
        end else if (cam_mode == 2) begin
            if (cam_wr_ack) cam_wr_req = 1'b0;
            else if (!cam_wr_req && $urandom_range(0, 3) == 0) begin
                new_cam(); cam_wr_req = 1'b1;
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin step(); n++; end while (busy && n < budget);
        check("idle_within_budget", busy, 0);
        idle_cyc = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
    endtask

    task automatic fetch(input int line);
        line_req = 1'b1; line_num = 8'(line);
        step();
        line_req = 1'b0;
    endtask

    typedef struct {
        bit lreq; int lnum; bit creq; bit e_re; bit e_we; bit e_busy; int e_addr; string name;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int s, base;
        vecs[0] = '{1, 5,   0, 1, 0, 1, 1600,    "v_line5"};
        vecs[1] = '{1, 239, 0, 1, 0, 1, 76480,   "v_line239"};
        vecs[2] = '{1, 240, 0, 0, 0, 0, 0,       "v_line240"};
        vecs[3] = '{0, 0,   1, 0, 1, 1, 'h1ABCD, "v_cam_only"};
        vecs[4] = '{1, 0,   1, 1, 0, 1, 0,       "v_line0_and_cam"};
        vecs[5] = '{0, 0,   0, 0, 0, 0, 0,       "v_quiet"};
        vecs[6] = '{1, 200, 0, 1, 0, 1, 64000,   "v_line200"};

        clear_stats();
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;

        // Single-decision vectors from IDLE
        foreach (vecs[i]) begin
            cam_wr_addr = 17'h1ABCD; cam_wr_data = 16'hBEEF;
            line_req = vecs[i].lreq; line_num = 8'(vecs[i].lnum); cam_wr_req = vecs[i].creq;
            step();
            line_req = 1'b0; cam_wr_req = 1'b0;
            check({vecs[i].name, "_re"}, mem_re, vecs[i].e_re);
            check({vecs[i].name, "_we"}, mem_we, vecs[i].e_we);
            check({vecs[i].name, "_ack"}, cam_wr_ack, vecs[i].e_we);
            check({vecs[i].name, "_busy"}, busy, vecs[i].e_busy);
            if (vecs[i].e_re || vecs[i].e_we) check({vecs[i].name, "_addr"}, mem_addr, vecs[i].e_addr);
            if (vecs[i].e_we) check({vecs[i].name, "_wdata"}, mem_wdata, 16'hBEEF);
            do_reset();
        end

        // Plain line fetch, no camera traffic
        clear_stats();
        fetch(5); s = cyc;
        run_until_idle(1000);
        check("s1_reads", n_re, 320);
        check("s1_first_addr", first_re_addr, 1600);
        check("s1_last_addr", last_re_addr, 1919);
        check("s1_lb_writes", n_lb, 320);
        check("s1_line_done", n_done, 1);
        check("s1_done_cycle", done_cyc - s, 321);
        check("s1_idle_cycle", idle_cyc - s, 322);
        base = idle_cyc - s;

        // Camera held continuously during the fetch
        clear_stats();
        fetch(5); s = cyc;
        cam_mode = 1; new_cam(); cam_wr_req = 1'b1;
        run_until_idle(1000);
        cam_mode = 0; cam_wr_req = 1'b0;
        check("s2_reads", n_re, 320);
        check("s2_last_addr", last_re_addr, 1919);
        check("s2_acks", n_ack, 40);
        check("s2_line_done", n_done, 1);
        check("s2_idle_delay", idle_cyc - s, base + 40);

        // line_req and cam_wr_req together in IDLE
        clear_stats();
        cam_mode = 1; new_cam(); cam_wr_req = 1'b1;
        fetch(5); s = cyc;
        check("s3_read_first", mem_re, 1);
        check("s3_no_write_first", mem_we, 0);
        run_until_idle(1000);
        cam_mode = 0; cam_wr_req = 1'b0;
        check("s3_first_ack_after_burst", first_ack_cyc - s, 8);
        check("s3_acks", n_ack, 40);

        // Overrun: second request at column 100, set and clear together
        clear_stats();
        fetch(7);
        for (int i = 0; i < 100; i++) step();
        line_req = 1'b1; line_num = 8'd9; overrun_clr = 1'b1;
        step();
        line_req = 1'b0; overrun_clr = 1'b0;
        check("s4_overrun_set", overrun, 1);
        run_until_idle(1000);
        check("s4_first_addr", first_re_addr, 2240);
        check("s4_last_addr", last_re_addr, 2559);
        check("s4_reads", n_re, 320);
        check("s4_overrun_sticky", overrun, 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("s4_overrun_cleared", overrun, 0);

        // Out-of-range lines are ignored
        clear_stats();
        fetch(240);
        for (int i = 0; i < 5; i++) step();
        fetch(255);
        for (int i = 0; i < 5; i++) step();
        check("s5_no_reads", n_re, 0);
        check("s5_never_busy", n_busy, 0);
        check("s5_no_done", n_done, 0);

        // Reset in the middle of a line
        clear_stats();
        fetch(3);
        for (int i = 0; i < 50; i++) step();
        reset = 1'b0;
        #1;
        check("s6_rst_mem_re", mem_re, 0);
        check("s6_rst_mem_we", mem_we, 0);
        check("s6_rst_ack", cam_wr_ack, 0);
        check("s6_rst_addr", mem_addr, 0);
        check("s6_rst_wdata", mem_wdata, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_lb_we", lb_we, 0);
        check("s6_rst_lb_waddr", lb_waddr, 0);
        check("s6_rst_lb_wdata", lb_wdata, 0);
        check("s6_rst_line_done", line_done, 0);
        check("s6_rst_overrun", overrun, 0);
        step(); step();
        reset = 1'b1;
        clear_stats();
        for (int i = 0; i < 10; i++) step();
        check("s6_no_lb_after", n_lb, 0);
        check("s6_no_done_after", n_done, 0);
        check("s6_no_reads_after", n_re, 0);
        clear_stats();
        fetch(4);
        run_until_idle(1000);
        check("s6_refetch_reads", n_re, 320);
        check("s6_refetch_first", first_re_addr, 1280);
        check("s6_refetch_done", n_done, 1);

        // Randomized traffic against the model
        cam_mode = 2;
        for (int i = 0; i < 5000; i++) begin
            line_req = ($urandom_range(0, busy ? 150 : 15) == 0);
            line_num = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(240, 255))
                                                   : 8'($urandom_range(0, 239));
            overrun_clr = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 2499) == 0) begin
                line_req = 1'b0;
                do_reset();
            end
            step();
        end
        line_req = 1'b0; overrun_clr = 1'b0; cam_mode = 0; cam_wr_req = 1'b0;
        run_until_idle(1000);
        for (int i = 0; i < 4; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
